// File: rtl/mode_scheduler.sv
// rtl/mode_scheduler.sv - mode sequencer and display/button arbiter with timer alert and idle return
module mode_scheduler #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int IDLE_SEC  = 30,
    parameter int ALERT_SEC = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_c,
    input  logic       timer_done,
    input  logic       hold_mode,
    output logic [1:0] rezhim,
    output logic [2:0] fwd_btn,
    output logic       alert,
    output logic       blink,
    output logic       idle_ret
);
    localparam int HALF = CLK_HZ / 2;
    localparam int PW   = $clog2(CLK_HZ);
    localparam int BW   = $clog2(HALF) + 1;
    localparam int IW   = $clog2(IDLE_SEC + 1);
    localparam int AW   = $clog2(ALERT_SEC + 1);

    typedef enum logic {S_RUN, S_ALERT} state_t;

    state_t        state_q, state_d;
    logic [1:0]    rezhim_q, rezhim_d, saved_q, saved_d;
    logic [2:0]    fwd_q, fwd_d;
    logic          alert_q, alert_d, blink_q, blink_d, idle_ret_q, idle_ret_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic [PW-1:0] presc_q;
    logic [BW-1:0] bdiv_q, bdiv_d;
    logic          sec_tick, any_fn, any_btn, cond_q, cond_d;

    assign sec_tick = (presc_q == PW'(CLK_HZ - 1));
    assign any_fn   = btn_a | btn_b | btn_c;
    assign any_btn  = any_fn | btn_mode;

    always_comb begin
        state_d    = state_q;
        rezhim_d   = rezhim_q;
        saved_d    = saved_q;
        alert_d    = alert_q;
        idle_d     = idle_q;
        acnt_d     = acnt_q;
        fwd_d      = 3'b000;
        idle_ret_d = 1'b0;
        case (state_q)
            S_RUN: begin
                if (timer_done) begin
                    state_d  = S_ALERT;
                    saved_d  = rezhim_q;
                    rezhim_d = 2'd2;
                    alert_d  = 1'b1;
                    acnt_d   = '0;
                    idle_d   = '0;
                end else if (btn_mode) begin
                    rezhim_d = rezhim_q + 2'd1;
                    idle_d   = '0;
                end else if (any_fn) begin
                    fwd_d  = {btn_c, btn_b, btn_a};
                    idle_d = '0;
                end else if (hold_mode) begin
                    idle_d = '0;
                end else if (idle_q == IW'(IDLE_SEC) && rezhim_q != 2'd0) begin
                    rezhim_d   = 2'd0;
                    idle_ret_d = 1'b1;
                    idle_d     = '0;
                end else if (sec_tick && idle_q != IW'(IDLE_SEC)) begin
                    idle_d = idle_q + IW'(1);
                end
            end
            S_ALERT: begin
                // The acknowledging press is swallowed; nothing is forwarded.
                if (any_btn || acnt_q == AW'(ALERT_SEC)) begin
                    state_d  = S_RUN;
                    rezhim_d = saved_q;
                    alert_d  = 1'b0;
                    idle_d   = '0;
                end else if (sec_tick) begin
                    acnt_d = acnt_q + AW'(1);
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Divider only runs once the condition has held for a full cycle, so the first low half is full length.
    assign cond_q = alert_q || (rezhim_q == 2'd1);
    assign cond_d = alert_d || (rezhim_d == 2'd1);

    always_comb begin
        bdiv_d  = bdiv_q + BW'(1);
        blink_d = blink_q;
        if (!(cond_d && cond_q)) begin
            bdiv_d  = '0;
            blink_d = 1'b0;
        end else if (bdiv_q == BW'(HALF - 1)) begin
            bdiv_d  = '0;
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_RUN;
            rezhim_q   <= 2'd0;
            saved_q    <= 2'd0;
            fwd_q      <= 3'b000;
            alert_q    <= 1'b0;
            blink_q    <= 1'b0;
            idle_ret_q <= 1'b0;
            idle_q     <= '0;
            acnt_q     <= '0;
            presc_q    <= '0;
            bdiv_q     <= '0;
        end else begin
            state_q    <= state_d;
            rezhim_q   <= rezhim_d;
            saved_q    <= saved_d;
            fwd_q      <= fwd_d;
            alert_q    <= alert_d;
            blink_q    <= blink_d;
            idle_ret_q <= idle_ret_d;
            idle_q     <= idle_d;
            acnt_q     <= acnt_d;
            presc_q    <= sec_tick ? '0 : presc_q + PW'(1);
            bdiv_q     <= bdiv_d;
        end
    end

    assign rezhim   = rezhim_q;
    assign fwd_btn  = fwd_q;
    assign alert    = alert_q;
    assign blink    = blink_q;
    assign idle_ret = idle_ret_q;
endmodule

// File: tb/tb_mode_scheduler.sv
// tb/tb_mode_scheduler.sv - directed self-checking bench for mode_scheduler
module tb_mode_scheduler;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0, btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b0;
    logic       timer_done = 1'b0, hold_mode = 1'b0;
    logic [1:0] rezhim;
    logic [2:0] fwd_btn;
    logic       alert, blink, idle_ret;
    int         errors = 0;
    int         checks = 0;
    int         ph = 0;

    mode_scheduler #(.CLK_HZ(10), .IDLE_SEC(3), .ALERT_SEC(2)) dut (
        .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_a(btn_a),
        .btn_b(btn_b), .btn_c(btn_c), .timer_done(timer_done), .hold_mode(hold_mode),
        .rezhim(rezhim), .fwd_btn(fwd_btn), .alert(alert), .blink(blink), .idle_ret(idle_ret)
    );

    always #5 clock = ~clock;

    // Free-running 1 s prescaler phase: a tick is sampled at the edge where ph==9.
    always @(posedge clock) ph <= (!reset || ph == 9) ? 0 : ph + 1;

    task automatic pulse(input logic m, input logic a, input logic b, input logic c, input logic t);
        @(negedge clock);
        btn_mode = m; btn_a = a; btn_b = b; btn_c = c; timer_done = t;
        @(negedge clock);
        btn_mode = 0; btn_a = 0; btn_b = 0; btn_c = 0; timer_done = 0;
    endtask

    task automatic test_reset;
        @(negedge clock);
        checks++;
        if ({rezhim, fwd_btn, alert, blink, idle_ret} !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000000", {rezhim, fwd_btn, alert, blink, idle_ret});
        end
        reset = 1'b1;
    endtask

    task automatic test_mode_advance;
        for (int i = 1; i <= 4; i++) begin
            pulse(1, 0, 0, 0, 0);
            checks++;
            if (rezhim !== 2'(i % 4)) begin
                errors++;
                $display("FAIL mode_advance_%0d: rezhim=%0d required %0d", i, rezhim, i % 4);
            end
            checks++;
            if (fwd_btn !== 3'b000) begin
                errors++;
                $display("FAIL mode_no_fwd_%0d: fwd_btn=%b required 000", i, fwd_btn);
            end
            repeat (4) @(negedge clock);
        end
    endtask

    task automatic test_fwd;
        repeat (3) pulse(1, 0, 0, 0, 0);
        pulse(0, 0, 1, 0, 0);
        checks++;
        if (fwd_btn !== 3'b010) begin
            errors++;
            $display("FAIL fwd_b: fwd_btn=%b required 010", fwd_btn);
        end
        @(negedge clock);
        checks++;
        if (fwd_btn !== 3'b000) begin
            errors++;
            $display("FAIL fwd_b_width: fwd_btn=%b required 000", fwd_btn);
        end
        pulse(1, 1, 0, 0, 0);
        checks++;
        if (rezhim !== 2'd0 || fwd_btn !== 3'b000) begin
            errors++;
            $display("FAIL mode_beats_fn: rezhim=%0d fwd_btn=%b required 0 000", rezhim, fwd_btn);
        end
    endtask

    task automatic test_alert_ack;
        repeat (3) pulse(1, 0, 0, 0, 0);
        pulse(0, 0, 0, 0, 1);
        checks++;
        if (rezhim !== 2'd2 || alert !== 1'b1 || blink !== 1'b0) begin
            errors++;
            $display("FAIL alert_entry: rezhim=%0d alert=%b blink=%b required 2 1 0", rezhim, alert, blink);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (blink !== 1'b0) begin
            errors++;
            $display("FAIL blink_low_half: blink=%b required 0", blink);
        end
        @(negedge clock);
        checks++;
        if (blink !== 1'b1) begin
            errors++;
            $display("FAIL blink_toggle: blink=%b required 1", blink);
        end
        pulse(0, 0, 0, 1, 0);
        checks++;
        if (rezhim !== 2'd3 || alert !== 1'b0 || blink !== 1'b0 || fwd_btn !== 3'b000) begin
            errors++;
            $display("FAIL alert_ack: rezhim=%0d alert=%b blink=%b fwd=%b required 3 0 0 000",
                     rezhim, alert, blink, fwd_btn);
        end
        @(negedge clock);
        checks++;
        if (fwd_btn !== 3'b000) begin
            errors++;
            $display("FAIL ack_consumed: fwd_btn=%b required 000", fwd_btn);
        end
    endtask

    task automatic test_alert_timeout;
        int exp_k;
        int got_k;
        pulse(0, 0, 0, 0, 1);
        exp_k = 21 - ph;
        got_k = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 5) timer_done = 1'b1;
            if (k == 6) timer_done = 1'b0;
            if (alert === 1'b0 && got_k < 0) got_k = k;
        end
        checks++;
        if (got_k != exp_k) begin
            errors++;
            $display("FAIL alert_timeout_cycle: ended after %0d cycles required %0d", got_k, exp_k);
        end
        checks++;
        if (rezhim !== 2'd3) begin
            errors++;
            $display("FAIL alert_timeout_restore: rezhim=%0d required 3", rezhim);
        end
    endtask

    task automatic test_idle_return;
        int exp_k;
        int ret_k;
        int pulses;
        int bad;
        pulse(1, 0, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        exp_k = 31 - ph;
        ret_k = -1;
        pulses = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            if (idle_ret === 1'b1) pulses++;
            if (rezhim === 2'd0 && ret_k < 0) begin
                ret_k = k;
                checks++;
                if (idle_ret !== 1'b1) begin
                    errors++;
                    $display("FAIL idle_ret_align: idle_ret=%b required 1", idle_ret);
                end
            end
        end
        checks++;
        if (ret_k != exp_k) begin
            errors++;
            $display("FAIL idle_return_cycle: returned after %0d cycles required %0d", ret_k, exp_k);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL idle_ret_pulses: saw %0d required 1", pulses);
        end
        hold_mode = 1'b1;
        pulse(1, 0, 0, 0, 0);
        bad = 0;
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (rezhim !== 2'd1) bad++;
            if (idle_ret === 1'b1) pulses++;
        end
        checks++;
        if (bad != 0 || pulses != 0) begin
            errors++;
            $display("FAIL hold_blocks_idle: %0d cycles off mode 1, %0d idle_ret pulses, required 0 0", bad, pulses);
        end
        hold_mode = 1'b0;
    endtask

    task automatic test_reset_mid_alert;
        pulse(0, 0, 0, 0, 1);
        checks++;
        if (rezhim !== 2'd2 || alert !== 1'b1) begin
            errors++;
            $display("FAIL alert_from_setup: rezhim=%0d alert=%b required 2 1", rezhim, alert);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checks++;
        if ({rezhim, fwd_btn, alert, blink, idle_ret} !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_alert: got %b required 00000000", {rezhim, fwd_btn, alert, blink, idle_ret});
        end
        pulse(0, 1, 0, 0, 0);
        checks++;
        if (fwd_btn !== 3'b001) begin
            errors++;
            $display("FAIL run_after_reset: fwd_btn=%b required 001", fwd_btn);
        end
        @(negedge clock);
        reset = 1'b0;
        timer_done = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        timer_done = 1'b0;
        checks++;
        if (alert !== 1'b0 || rezhim !== 2'd0) begin
            errors++;
            $display("FAIL reset_beats_timer: alert=%b rezhim=%0d required 0 0", alert, rezhim);
        end
        @(negedge clock);
        checks++;
        if (alert !== 1'b0) begin
            errors++;
            $display("FAIL reset_beats_timer_after: alert=%b required 0", alert);
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        test_reset;
        test_mode_advance;
        test_fwd;
        test_alert_ack;
        test_alert_timeout;
        test_idle_return;
        test_reset_mid_alert;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
